// File: rtl/jts16b_mcu_pkg.sv
// Shared types and bus widths for the 8751 MCU to System 16B mapper bridge.
package jts16b_mcu_pkg;

  localparam int MCU_AW = 16;
  localparam int MCU_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mcu_st_t;

endpackage

// File: rtl/jts16b_mcu_bridge_if.sv
// Mapper-side MCU access port: one-cycle strobe with held address/data, read data one clk later.
interface jts16b_mcu_bridge_if;
  import jts16b_mcu_pkg::*;

  logic              map_acc;
  logic              map_wr;
  logic [MCU_AW-1:0] map_addr;
  logic [MCU_DW-1:0] map_dout;
  logic [MCU_DW-1:0] map_din;

  modport master (
    output map_acc,
    output map_wr,
    output map_addr,
    output map_dout,
    input  map_din
  );

  modport slave (
    input  map_acc,
    input  map_wr,
    input  map_addr,
    input  map_dout,
    output map_din
  );

endinterface

// File: rtl/jts16b_mcu_sync.sv
// Multi-flop synchroniser, per-bit, with a selectable asynchronous reset value.
module jts16b_mcu_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] ff [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= RST_VAL;
    end else begin
      ff[0] <= din;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign dout = ff[STAGES-1];

endmodule

// File: rtl/jts16b_mcu_bridge.sv
// Bridges 8751 external-memory accesses (clk24) to the mapper port (clk) with a toggle
// handshake, stalls the MCU through its clock enable and sequences the MCU reset release.
module jts16b_mcu_bridge
  import jts16b_mcu_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VINT_EDGES  = 2
) (
  input  logic              clk24,
  input  logic              rst24,
  input  logic              clk,
  input  logic              vint,
  input  logic              cen_in,
  output logic              cen_out,
  output logic              mcu_rst,
  input  logic              x_acc,
  input  logic              x_wr,
  input  logic [MCU_AW-1:0] x_addr,
  input  logic [MCU_DW-1:0] x_dout,
  output logic [MCU_DW-1:0] x_din,
  input  logic [1:0]        mintn_in,
  output logic [1:0]        mintn_out,
  jts16b_mcu_bridge_if.master map
);

  localparam logic [2:0] VMAX = 3'(VINT_EDGES);

  logic              vint_s, vint_l;
  logic [2:0]        vcnt;
  mcu_st_t           st;
  logic              req_t, ack_s, cen_en, acc_go;
  logic              wr_l;
  logic [MCU_AW-1:0] addr_l;
  logic [MCU_DW-1:0] dout_l;
  logic [MCU_DW-1:0] rd_data;
  logic              rst_clk, req_s, req_l, acc_p1, ack_t;

  jts16b_mcu_sync #(.W(1), .STAGES(SYNC_STAGES)) u_vint (
    .clk(clk24), .rst(rst24), .din(vint), .dout(vint_s)
  );

  jts16b_mcu_sync #(.W(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b11)) u_mint (
    .clk(clk24), .rst(rst24), .din(mintn_in), .dout(mintn_out)
  );

  jts16b_mcu_sync #(.W(1), .STAGES(SYNC_STAGES)) u_ack (
    .clk(clk24), .rst(rst24), .din(ack_t), .dout(ack_s)
  );

  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      vint_l <= 1'b0;
      vcnt   <= 3'd0;
    end else begin
      vint_l <= vint_s;
      if (vint_s && !vint_l && vcnt != VMAX) vcnt <= vcnt + 3'd1;
    end
  end

  // Release lands half a cycle after the count saturates, away from the MCU's sampling edge
  always_ff @(negedge clk24 or posedge rst24) begin
    if (rst24)             mcu_rst <= 1'b1;
    else if (vcnt == VMAX) mcu_rst <= 1'b0;
  end

  assign acc_go  = (st == IDLE) && x_acc && cen_in && !mcu_rst;
  assign cen_out = cen_in & cen_en & ~rst24;

  always_ff @(posedge clk24 or posedge rst24) begin
    if (rst24) begin
      st     <= IDLE;
      req_t  <= 1'b0;
      cen_en <= 1'b1;
      x_din  <= 8'hFF;
    end else begin
      case (st)
        IDLE: if (acc_go) begin
          req_t  <= ~req_t;
          cen_en <= 1'b0;
          st     <= WAIT;
        end
        WAIT: if (ack_s == req_t) begin
          if (!wr_l) x_din <= rd_data;
          cen_en <= 1'b1;
          st     <= DONE;
        end
        DONE: if (cen_in && !x_acc) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  // Request payload stays frozen while the MCU is stalled, so the clk side may read it freely
  always_ff @(posedge clk24) begin
    if (acc_go) begin
      wr_l   <= x_wr;
      addr_l <= x_addr;
      dout_l <= x_dout;
    end
  end

  jts16b_mcu_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rst_clk (
    .clk(clk), .rst(rst24), .din(1'b0), .dout(rst_clk)
  );

  jts16b_mcu_sync #(.W(1), .STAGES(SYNC_STAGES)) u_req (
    .clk(clk), .rst(rst_clk), .din(req_t), .dout(req_s)
  );

  // p0: request toggle detected -> map_acc strobe; p1: read data back, ack toggles
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      req_l        <= 1'b0;
      acc_p1       <= 1'b0;
      ack_t        <= 1'b0;
      map.map_acc  <= 1'b0;
      map.map_wr   <= 1'b0;
      map.map_addr <= '0;
      map.map_dout <= '0;
    end else begin
      req_l       <= req_s;
      map.map_acc <= req_s ^ req_l;
      acc_p1      <= map.map_acc;
      if (req_s ^ req_l) begin
        map.map_wr   <= wr_l;
        map.map_addr <= addr_l;
        map.map_dout <= dout_l;
      end
      if (acc_p1) ack_t <= ~ack_t;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_p1 && !map.map_wr) rd_data <= map.map_din;
  end

endmodule

// File: tb/tb_jts16b_mcu_bridge.sv
// Directed and randomized checks of the MCU bridge against a memory-level reference model.
module tb_jts16b_mcu_bridge;
  import jts16b_mcu_pkg::*;

  logic        clk24 = 1'b0, clk = 1'b0, rst24 = 1'b0, vint = 1'b0, cen_in = 1'b0;
  logic        x_acc = 1'b0, x_wr = 1'b0;
  logic [15:0] x_addr = '0;
  logic [7:0]  x_dout = '0;
  logic [1:0]  mintn_in = 2'b11;
  logic        cen_out, mcu_rst;
  logic [7:0]  x_din;
  logic [1:0]  mintn_out;

  jts16b_mcu_bridge_if map_if();

  jts16b_mcu_bridge #(.SYNC_STAGES(2), .VINT_EDGES(2)) dut (
    .clk24(clk24), .rst24(rst24), .clk(clk), .vint(vint), .cen_in(cen_in),
    .cen_out(cen_out), .mcu_rst(mcu_rst), .x_acc(x_acc), .x_wr(x_wr),
    .x_addr(x_addr), .x_dout(x_dout), .x_din(x_din), .mintn_in(mintn_in),
    .mintn_out(mintn_out), .map(map_if)
  );

  always #21 clk24 = ~clk24;
  always #10 clk   = ~clk;

  int errs = 0, checks = 0;
  int acc_cnt = 0;
  logic [15:0] m_addr = '0;
  logic        m_wr = 1'b0;
  logic [7:0]  m_dout = '0;
  logic [7:0]  exp_xdin = 8'hFF;
  logic [7:0]  dev_mem [logic [15:0]];
  logic [7:0]  ref_mem [logic [15:0]];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [15:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Random raw MCU clock enable, changed shortly after each clk24 rising edge
  initial begin
    forever begin
      @(posedge clk24);
      #5 cen_in = 1'($urandom_range(0, 1));
    end
  end

  // Mapper: counts strobes, stores writes, returns read data one clk after the strobe
  initial begin
    map_if.map_din = 8'hFF;
    forever begin
      @(negedge clk);
      if (map_if.map_acc === 1'b1) begin
        acc_cnt++;
        m_addr = map_if.map_addr;
        m_wr   = map_if.map_wr;
        m_dout = map_if.map_dout;
        if (m_wr) dev_mem[m_addr] = m_dout;
        map_if.map_din = dev_rd(m_addr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset(input string pfx);
    chk({pfx, "_mcu_rst"},  32'(mcu_rst),          32'd1);
    chk({pfx, "_cen_out"},  32'(cen_out),          32'd0);
    chk({pfx, "_x_din"},    32'(x_din),            32'hFF);
    chk({pfx, "_mintn"},    32'(mintn_out),        32'h3);
    chk({pfx, "_map_acc"},  32'(map_if.map_acc),   32'd0);
    chk({pfx, "_map_wr"},   32'(map_if.map_wr),    32'd0);
    chk({pfx, "_map_addr"}, 32'(map_if.map_addr),  32'd0);
    chk({pfx, "_map_dout"}, 32'(map_if.map_dout),  32'd0);
  endtask

  task automatic vint_pulse();
    @(negedge clk) vint = 1'b1;
    repeat (8) @(negedge clk);
    vint = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin @(posedge clk24); n++; end while (cen_in !== 1'b1 && n < 200);
  endtask

  task automatic mcu_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                            input int hold);
    int   base, n;
    logic ok, stalled;
    @(negedge clk24);
    base = acc_cnt;
    x_acc = 1'b1; x_wr = wr; x_addr = a; x_dout = d;
    wait_accept();
    ok = 1'b0; stalled = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk24);
      if (cen_out === 1'b1) ok = 1'b1; else stalled = 1'b1;
    end
    if (wr) ref_mem[a] = d; else exp_xdin = ref_rd(a);
    chk("acc_done",  32'(ok),            32'd1);
    chk("acc_stall", 32'(stalled),       32'd1);
    chk("x_din",     32'(x_din),         32'(exp_xdin));
    chk("acc_count", acc_cnt - base,     32'd1);
    chk("map_addr",  32'(m_addr),        32'(a));
    chk("map_wr",    32'(m_wr),          32'(wr));
    if (wr) chk("map_dout", 32'(m_dout), 32'(d));
    n = 0;
    for (int i = 0; i < 400 && n < hold; i++) begin
      @(posedge clk24);
      if (cen_in) n++;
    end
    @(negedge clk24);
    x_acc = 1'b0;
    wait_accept();
    repeat (12) @(negedge clk24);
    chk("acc_once", acc_cnt - base, 32'd1);
  endtask

  initial begin
    int   base;
    logic got, lvl;

    // Reset values while rst24 is held
    #3 rst24 = 1'b1;
    repeat (3) @(negedge clk24);
    chk_reset("rst");
    rst24 = 1'b0;
    repeat (10) @(negedge clk24);

    // Accesses before the MCU is released are ignored
    repeat (10) begin
      @(negedge clk24);
      chk("pre_cen", 32'(cen_out), 32'(cen_in));
      x_acc  = ~x_acc;
      x_addr = 16'($urandom);
    end
    x_acc = 1'b0;
    repeat (20) @(negedge clk24);
    chk("pre_noacc", acc_cnt, 32'd0);

    // Reset release after the second vint edge, on a falling clk24 edge
    vint_pulse();
    repeat (10) @(negedge clk24);
    chk("rst_after_1", 32'(mcu_rst), 32'd1);
    @(negedge clk) vint = 1'b1;
    got = 1'b0; lvl = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(clk24); #1;
      if (mcu_rst === 1'b0) begin got = 1'b1; lvl = clk24; end
    end
    chk("rst_release",    32'(got), 32'd1);
    chk("rst_on_negedge", 32'(lvl), 32'd0);
    repeat (8) @(negedge clk);
    vint = 1'b0;
    vint_pulse();
    repeat (10) @(negedge clk24);
    chk("rst_after_3", 32'(mcu_rst), 32'd0);

    // Directed read, write and held strobe
    dev_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    mcu_access(1'b0, 16'h1234, 8'h00, 0);
    chk("read_a5", 32'(x_din), 32'hA5);
    mcu_access(1'b1, 16'h00FF, 8'h3C, 0);
    chk("write_keep", 32'(x_din), 32'hA5);
    mcu_access(1'b0, 16'h00FF, 8'h00, 20);
    chk("read_back_3c", 32'(x_din), 32'h3C);

    // Interrupt lines
    repeat (4) begin
      @(negedge clk) mintn_in = 2'($urandom);
      repeat (6) @(negedge clk24);
      chk("mintn", 32'(mintn_out), 32'(mintn_in));
    end

    // Randomized accesses, with a vint edge overlapping one of them
    for (int k = 0; k < 12; k++) begin
      if (k == 5) fork vint_pulse(); join_none
      mcu_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 8'($urandom),
                 int'($urandom_range(0, 3)));
    end
    chk("mcu_rst_kept", 32'(mcu_rst), 32'd0);

    // Reset while the MCU is stalled
    @(negedge clk24);
    x_acc = 1'b1; x_wr = 1'b0; x_addr = 16'h4321;
    wait_accept();
    @(negedge clk24);
    chk("mid_stall", 32'(cen_out), 32'd0);
    rst24 = 1'b1;
    #1;
    chk_reset("mid");
    x_acc = 1'b0;
    exp_xdin = 8'hFF;
    repeat (5) @(negedge clk24);
    rst24 = 1'b0;
    repeat (10) @(negedge clk24);
    base = acc_cnt;
    vint_pulse();
    vint_pulse();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk24);
      if (mcu_rst === 1'b0) got = 1'b1;
    end
    chk("mid_release", 32'(got), 32'd1);
    chk("mid_noacc", acc_cnt - base, 32'd0);
    dev_mem[16'h0002] = 8'h5A; ref_mem[16'h0002] = 8'h5A;
    mcu_access(1'b0, 16'h0002, 8'h00, 0);
    chk("mid_read_5a", 32'(x_din), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/jts16b_mcu_bridge.md
Name: jts16b_mcu_bridge

Overview:
Clock-domain bridge between the 8751 MCU external-memory port (clk24 domain) and the System 16B mapper MCU port (main clk domain).
- Converts each MCU external access into a single-cycle request in the clk domain and returns read data.
- Stalls the MCU via clock-enable gating until the access completes.
- Owns the MCU reset release: the MCU leaves reset after VINT_EDGES vertical-interrupt rising edges.
- Synchronises the mapper interrupt lines into clk24.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of every CDC synchroniser (2 or 3).
- VINT_EDGES, 2, vint rising edges counted after reset before mcu_rst deasserts (1..7).

Ports:
- clk24  in  1  MCU clock.
- rst24  in  1  Reset: asynchronous, active-high, in the clk24 domain.
- clk  in  1  Main/mapper clock. Its registers are reset by rst24, synchronised into clk (async assert, sync deassert).
- vint  in  1  Vertical interrupt, clk domain.
- cen_in  in  1  Raw MCU clock enable, clk24 domain.
- cen_out  out  1  Gated MCU clock enable to the MCU.
- mcu_rst  out  1  MCU reset.
- x_acc  in  1  MCU external access strobe.
- x_wr  in  1  1 = write.
- x_addr  in  16  MCU external address.
- x_dout  in  8  MCU write data.
- x_din  out  8  Read data to the MCU.
- mintn_in  in  2  Mapper interrupt lines, clk domain, active low.
- mintn_out  out  2  Synchronised interrupt lines to the MCU.
- map_acc  out  1  One-clk access pulse to the mapper.
- map_wr  out  1  Write qualifier, valid with map_acc.
- map_addr  out  16  Address, held stable from map_acc until the next request.
- map_dout  out  8  Write data, held like map_addr.
- map_din  in  8  Mapper read data, valid 1 clk after map_acc.

Behaviour:
Reset values:
- mcu_rst = 1, cen_out = 0, x_din = 0xFF, mintn_out = 2'b11.
- map_acc = 0, map_wr = 0, map_addr = 0, map_dout = 0.
- req_t = 0, ack_t = 0, FSM in IDLE, edge count = 0.

Reset sequencer (clk24):
- vint passes through an SYNC_STAGES synchroniser, then rising-edge detection.
- A 3-bit counter increments per edge and saturates at VINT_EDGES.
- mcu_rst is driven low on the clk24 falling edge after the counter reaches VINT_EDGES.
- mcu_rst stays low until the next rst24.

Interrupts:
- mintn_out is mintn_in through an SYNC_STAGES synchroniser, per bit.
- No filtering.

MCU-side FSM (clk24):
- IDLE:
  - cen_out = cen_in.
  - On x_acc & cen_in & !mcu_rst: latch x_addr, x_dout and x_wr; toggle req_t; go to WAIT.
- WAIT:
  - cen_out = 0.
  - When synchronised ack_t equals req_t: capture rd_data into x_din (writes leave x_din unchanged); go to DONE.
- DONE:
  - cen_out = cen_in.
  - Stay until x_acc is low on a cen_in cycle, then go to IDLE. This prevents one long strobe from issuing a duplicate request.
- While mcu_rst is high, x_acc is ignored.

Clk-side engine:
- req_t passes through an SYNC_STAGES synchroniser.
- On each change of the synchronised req_t:
  - Cycle 0: map_acc = 1; map_addr, map_dout and map_wr are driven from the latched MCU values. The latched MCU values are stable: the MCU is stalled from before the toggle.
  - Cycle 1: rd_data <= map_din (reads only); toggle ack_t.
- Only one request can be in flight at a time; the toggle protocol guarantees this.
- Worst-case stall is about 2*SYNC_STAGES clk24 + SYNC_STAGES+2 clk cycles.

Boundary conditions:
- rst24 during WAIT: both domains return to reset values and toggles realign to 0. An in-flight map_acc may complete, but its ack is discarded.
- vint edge coinciding with an access has no interaction.
- Back-to-back MCU accesses are separated by at least one non-acc cen_in cycle, per the DONE rule.
- cen_in low while in WAIT: the FSM still completes; cen_out stays 0 until DONE.

Decomposition:
- Shared package jts16b_mcu_pkg:
  - FSM state enum (IDLE, WAIT, DONE).
  - MCU_AW = 16, MCU_DW = 8.
- Sub-module jts16b_mcu_sync:
  - Parameterised width/depth bit synchroniser.
  - Used for vint, req_t, ack_t, mintn and the clk-domain reset deassert.

Test Plan:
- Reset release: rst24 pulse, then 3 vint pulses -> mcu_rst high through the first edge; low after the 2nd synchronised edge on a clk24 negedge; still low after the 3rd.
- Read: x_acc=1, x_wr=0, x_addr=0x1234, map_din=0xA5 -> exactly one map_acc pulse with map_addr=0x1234, map_wr=0; cen_out=0 during WAIT; x_din=0xA5 at DONE.
- Write: x_wr=1, x_addr=0x00FF, x_dout=0x3C -> one map_acc with map_wr=1, map_dout=0x3C; x_din unchanged.
- Held strobe: x_acc held high for 20 cen_in cycles -> exactly one map_acc; a second map_acc only after x_acc drops and rises again.
- Accesses before release: x_acc pulses while mcu_rst=1 -> no map_acc, cen_out follows cen_in.
- Mid-op reset: rst24 asserted during WAIT -> immediate reset values; a following read to 0x0002 with map_din=0x5A returns 0x5A with a single map_acc.
